// File: rtl/axi_node_cfg_pkg.sv
// Shared definitions for the AXI node address-map configuration block:
// register offsets, CTRL bit positions and the commit FSM states.
package axi_node_cfg_pkg;

    localparam logic [11:0] CTRL_OFFS = 12'h000;
    localparam logic [11:0] CONN_OFFS = 12'h080;
    localparam logic [11:0] RULE_OFFS = 12'h100;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_DIRTY  = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_OVF    = 3;

    typedef enum logic [1:0] {
        IDLE,
        BLOCK,
        DRAIN,
        UPDATE
    } cfg_state_e;

endpackage

// File: rtl/axi_node_outstanding_cnt.sv
// Saturating outstanding-transaction counter for one port and direction.
// ovf flags a dec at zero or an inc at the limit; the count then holds.
module axi_node_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic at_max;
    logic at_zero;

    assign at_max  = (cnt == CNT_MAX);
    assign at_zero = (cnt == '0);
    assign zero    = at_zero;
    assign ovf     = (inc & ~dec & at_max) | (dec & ~inc & at_zero);

    // Count accepted requests up and completions down, holding at the limits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !at_max) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && !at_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_node_map_cfg.sv
// Run-time address-map controller: shadow registers behind a req/gnt port,
// committed to the active map only after all node slave ports have drained.
module axi_node_map_cfg
    import axi_node_cfg_pkg::*;
#(
    parameter int NB_MASTER       = 8,
    parameter int NB_SLAVE        = 4,
    parameter int NB_REGION       = 2,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_req_i,
    input  logic                cfg_we_i,
    input  logic [11:0]         cfg_addr_i,
    input  logic [31:0]         cfg_wdata_i,
    output logic                cfg_gnt_o,
    output logic                cfg_rvalid_o,
    output logic [31:0]         cfg_rdata_o,
    output logic                cfg_err_o,
    input  logic [NB_SLAVE-1:0] aw_hs_i,
    input  logic [NB_SLAVE-1:0] ar_hs_i,
    input  logic [NB_SLAVE-1:0] b_hs_i,
    input  logic [NB_SLAVE-1:0] rlast_hs_i,
    output logic [NB_SLAVE-1:0] block_o,
    output logic                commit_done_o,
    output logic [NB_REGION-1:0][NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] start_addr_o,
    output logic [NB_REGION-1:0][NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] end_addr_o,
    output logic [NB_REGION-1:0][NB_MASTER-1:0] valid_rule_o,
    output logic [NB_SLAVE-1:0][NB_MASTER-1:0]  connectivity_map_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);

    cfg_state_e state;
    logic [TMO_W-1:0] tmo;
    logic dirty;
    logic abort;
    logic ovf;

    logic [NB_REGION-1:0][NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] sh_start;
    logic [NB_REGION-1:0][NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] sh_end;
    logic [NB_REGION-1:0][NB_MASTER-1:0] sh_valid;
    logic [NB_SLAVE-1:0][NB_MASTER-1:0]  sh_conn;

    logic [11:0] waddr;
    logic [1:0]  rword;
    logic        hit_ctrl;
    logic        hit_any;
    logic [NB_SLAVE-1:0] conn_hit;
    logic [NB_REGION-1:0][NB_MASTER-1:0] rule_hit;
    logic [31:0] rd_data;

    logic wr_en;
    logic sh_wr;
    logic commit_req;
    logic clr_abort;
    logic clr_ovf;

    logic [NB_SLAVE-1:0][CNT_W-1:0] wr_cnt;
    logic [NB_SLAVE-1:0][CNT_W-1:0] rd_cnt;
    logic [NB_SLAVE-1:0] wr_zero;
    logic [NB_SLAVE-1:0] rd_zero;
    logic [NB_SLAVE-1:0] wr_ovf;
    logic [NB_SLAVE-1:0] rd_ovf;
    logic all_zero;
    logic ovf_evt;
    logic unused_ok;

    assign waddr = {cfg_addr_i[11:2], 2'b00};
    assign rword = waddr[3:2];

    for (genvar s = 0; s < NB_SLAVE; s++) begin : g_cnt
        axi_node_outstanding_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) u_wr_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (aw_hs_i[s]),
            .dec   (b_hs_i[s]),
            .cnt   (wr_cnt[s]),
            .zero  (wr_zero[s]),
            .ovf   (wr_ovf[s])
        );
        axi_node_outstanding_cnt #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .CNT_W           (CNT_W)
        ) u_rd_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (ar_hs_i[s]),
            .dec   (rlast_hs_i[s]),
            .cnt   (rd_cnt[s]),
            .zero  (rd_zero[s]),
            .ovf   (rd_ovf[s])
        );
    end

    assign all_zero  = &{wr_zero, rd_zero};
    assign ovf_evt   = |{wr_ovf, rd_ovf};
    assign unused_ok = ^{cfg_addr_i[1:0], wr_cnt, rd_cnt};

    // Address decode: one-hot hits for connectivity rows and rule slots
    always_comb begin
        conn_hit = '0;
        rule_hit = '0;
        for (int s = 0; s < NB_SLAVE; s++) begin
            conn_hit[s] = (waddr == CONN_OFFS + 12'(4 * s));
        end
        for (int r = 0; r < NB_REGION; r++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                rule_hit[r][m] = ({waddr[11:4], 4'h0} ==
                                  RULE_OFFS + 12'(16 * (r * NB_MASTER + m)));
            end
        end
    end

    assign hit_ctrl = (waddr == CTRL_OFFS);
    assign hit_any  = hit_ctrl | (|conn_hit) | (|rule_hit);

    assign cfg_gnt_o  = cfg_req_i & (~cfg_we_i | (state == IDLE));
    assign wr_en      = cfg_gnt_o & cfg_we_i;
    assign sh_wr      = wr_en & ((|conn_hit) | ((|rule_hit) & (rword != 2'd3)));
    assign commit_req = wr_en & hit_ctrl & cfg_wdata_i[CTRL_COMMIT];
    assign clr_abort  = wr_en & hit_ctrl & cfg_wdata_i[CTRL_ABORT];
    assign clr_ovf    = wr_en & hit_ctrl & cfg_wdata_i[CTRL_OVF];

    // Read mux: status word, shadow rows and shadow rules (reserved word reads 0)
    always_comb begin
        rd_data = '0;
        if (hit_ctrl) begin
            rd_data[CTRL_BUSY]  = (state != IDLE);
            rd_data[CTRL_DIRTY] = dirty;
            rd_data[CTRL_ABORT] = abort;
            rd_data[CTRL_OVF]   = ovf;
        end
        for (int s = 0; s < NB_SLAVE; s++) begin
            if (conn_hit[s]) rd_data[NB_MASTER-1:0] = sh_conn[s];
        end
        for (int r = 0; r < NB_REGION; r++) begin
            for (int m = 0; m < NB_MASTER; m++) begin
                if (rule_hit[r][m]) begin
                    case (rword)
                        2'd0:    rd_data[AXI_ADDR_WIDTH-1:0] = sh_start[r][m];
                        2'd1:    rd_data[AXI_ADDR_WIDTH-1:0] = sh_end[r][m];
                        2'd2:    rd_data[0] = sh_valid[r][m];
                        default: rd_data = '0;
                    endcase
                end
            end
        end
    end

    // Registered response, one cycle after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_gnt_o;
            cfg_err_o    <= cfg_gnt_o & ~hit_any;
            if (cfg_gnt_o) cfg_rdata_o <= cfg_we_i ? '0 : rd_data;
        end
    end

    // Shadow register writes; writes are only granted while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start <= '0;
            sh_end   <= '0;
            sh_valid <= '0;
            sh_conn  <= '1;
        end else if (wr_en) begin
            for (int s = 0; s < NB_SLAVE; s++) begin
                if (conn_hit[s]) sh_conn[s] <= cfg_wdata_i[NB_MASTER-1:0];
            end
            for (int r = 0; r < NB_REGION; r++) begin
                for (int m = 0; m < NB_MASTER; m++) begin
                    if (rule_hit[r][m]) begin
                        case (rword)
                            2'd0:    sh_start[r][m] <= cfg_wdata_i[AXI_ADDR_WIDTH-1:0];
                            2'd1:    sh_end[r][m]   <= cfg_wdata_i[AXI_ADDR_WIDTH-1:0];
                            2'd2:    sh_valid[r][m] <= cfg_wdata_i[0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Commit FSM: block ports, drain, copy shadow to active, release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            tmo                <= '0;
            block_o            <= '0;
            commit_done_o      <= 1'b0;
            dirty              <= 1'b0;
            abort              <= 1'b0;
            ovf                <= 1'b0;
            start_addr_o       <= '0;
            end_addr_o         <= '0;
            valid_rule_o       <= '0;
            connectivity_map_o <= '1;
        end else begin
            commit_done_o <= 1'b0;
            if (sh_wr)     dirty <= 1'b1;
            if (clr_abort) abort <= 1'b0;
            if (clr_ovf)   ovf   <= 1'b0;
            if (ovf_evt)   ovf   <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (commit_req) begin
                        state   <= BLOCK;
                        block_o <= '1;
                    end
                end
                BLOCK: begin
                    state <= DRAIN;
                    tmo   <= '0;
                end
                DRAIN: begin
                    if (all_zero) begin
                        state <= UPDATE;
                    end else if (tmo == TMO_W'(DRAIN_TIMEOUT - 1)) begin
                        state   <= IDLE;
                        abort   <= 1'b1;
                        block_o <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                UPDATE: begin
                    start_addr_o       <= sh_start;
                    end_addr_o         <= sh_end;
                    valid_rule_o       <= sh_valid;
                    connectivity_map_o <= sh_conn;
                    commit_done_o      <= 1'b1;
                    block_o            <= '0;
                    dirty              <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_node_map_cfg.sv
// Self-checking bench for axi_node_map_cfg: random register and handshake
// traffic against a behavioural model of the register map and commit flow.
module tb_axi_node_map_cfg;

    localparam int NBM  = 8;
    localparam int NBS  = 4;
    localparam int NBR  = 2;
    localparam int AW   = 32;
    localparam int MAXO = 16;
    localparam int TMO  = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_req = 1'b0;
    logic cfg_we = 1'b0;
    logic [11:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic cfg_gnt, cfg_rvalid, cfg_err;
    logic [31:0] cfg_rdata;
    logic [NBS-1:0] aw_hs = '0, ar_hs = '0, b_hs = '0, rlast_hs = '0;
    logic [NBS-1:0] block;
    logic commit_done;
    logic [NBR-1:0][NBM-1:0][AW-1:0] start_addr, end_addr;
    logic [NBR-1:0][NBM-1:0] valid_rule;
    logic [NBS-1:0][NBM-1:0] conn_map;

    axi_node_map_cfg #(
        .NB_MASTER(NBM), .NB_SLAVE(NBS), .NB_REGION(NBR),
        .AXI_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid),
        .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .aw_hs_i(aw_hs), .ar_hs_i(ar_hs), .b_hs_i(b_hs), .rlast_hs_i(rlast_hs),
        .block_o(block), .commit_done_o(commit_done),
        .start_addr_o(start_addr), .end_addr_o(end_addr),
        .valid_rule_o(valid_rule), .connectivity_map_o(conn_map)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_start [NBR][NBM];
    logic [31:0] m_end   [NBR][NBM];
    bit          m_valid [NBR][NBM];
    logic [NBM-1:0] m_conn [NBS];
    logic [31:0] a_start [NBR][NBM];
    logic [31:0] a_end   [NBR][NBM];
    bit          a_valid [NBR][NBM];
    logic [NBM-1:0] a_conn [NBS];
    int wcnt [NBS];
    int rcnt [NBS];
    bit m_dirty, m_abort, m_ovf, m_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NBR; r++)
            for (int m = 0; m < NBM; m++) begin
                m_start[r][m] = 0; m_end[r][m] = 0; m_valid[r][m] = 0;
                a_start[r][m] = 0; a_end[r][m] = 0; a_valid[r][m] = 0;
            end
        for (int s = 0; s < NBS; s++) begin
            m_conn[s] = '1; a_conn[s] = '1; wcnt[s] = 0; rcnt[s] = 0;
        end
        m_dirty = 0; m_abort = 0; m_ovf = 0; m_busy = 0;
    endtask

    task automatic model_commit();
        for (int r = 0; r < NBR; r++)
            for (int m = 0; m < NBM; m++) begin
                a_start[r][m] = m_start[r][m];
                a_end[r][m]   = m_end[r][m];
                a_valid[r][m] = m_valid[r][m];
            end
        for (int s = 0; s < NBS; s++) a_conn[s] = m_conn[s];
        m_dirty = 0;
    endtask

    function automatic int step(input int c, input bit inc, input bit dec);
        if (inc && !dec) begin
            if (c == MAXO) m_ovf = 1; else c++;
        end else if (dec && !inc) begin
            if (c == 0) m_ovf = 1; else c--;
        end
        return c;
    endfunction

    // kind: 0 unmapped, 1 ctrl, 2 connectivity row, 3 rule word
    function automatic void decode(input logic [11:0] addr, output int kind,
                                   output int idx, output int w);
        int a;
        a = int'(addr) & ~3;
        kind = 0; idx = 0; w = 0;
        if (a == 0) kind = 1;
        else if (a >= 128 && a < 128 + 4 * NBS) begin
            kind = 2; idx = (a - 128) / 4;
        end else if (a >= 256 && a < 256 + 16 * NBR * NBM) begin
            kind = 3; idx = (a - 256) / 16; w = (a % 16) / 4;
        end
    endfunction

    function automatic void exp_read(input logic [11:0] addr, output logic [31:0] d,
                                     output logic e);
        int kind, idx, w, r, m;
        decode(addr, kind, idx, w);
        d = 0; e = 0;
        r = idx / NBM; m = idx % NBM;
        case (kind)
            0: e = 1;
            1: d = {28'd0, m_ovf, m_abort, m_dirty, m_busy};
            2: d = 32'(m_conn[idx]);
            default: begin
                if (w == 0) d = m_start[r][m];
                else if (w == 1) d = m_end[r][m];
                else if (w == 2) d = 32'(m_valid[r][m]);
            end
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] addr, input logic [31:0] wd);
        int kind, idx, w, r, m;
        decode(addr, kind, idx, w);
        r = idx / NBM; m = idx % NBM;
        if (kind == 1) begin
            if (wd[2]) m_abort = 0;
            if (wd[3]) m_ovf = 0;
        end else if (kind == 2) begin
            m_conn[idx] = wd[NBM-1:0]; m_dirty = 1;
        end else if (kind == 3 && w < 3) begin
            if (w == 0) m_start[r][m] = wd;
            else if (w == 1) m_end[r][m] = wd;
            else m_valid[r][m] = wd[0];
            m_dirty = 1;
        end
    endfunction

    function automatic logic [NBR*NBM-1:0] exp_valid();
        logic [NBR*NBM-1:0] v;
        for (int r = 0; r < NBR; r++)
            for (int m = 0; m < NBM; m++) v[r*NBM+m] = a_valid[r][m];
        return v;
    endfunction

    function automatic logic [NBS*NBM-1:0] exp_conn();
        logic [NBS*NBM-1:0] v;
        for (int s = 0; s < NBS; s++) v[s*NBM +: NBM] = a_conn[s];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic compare_active(input string tag);
        chk({tag, "_valid"}, 32'(valid_rule), 32'(exp_valid()));
        chk({tag, "_conn"}, 32'(conn_map), 32'(exp_conn()));
        for (int r = 0; r < NBR; r++)
            for (int m = 0; m < NBM; m++) begin
                chk($sformatf("%s_start%0d_%0d", tag, r, m), start_addr[r][m], a_start[r][m]);
                chk($sformatf("%s_end%0d_%0d", tag, r, m), end_addr[r][m], a_end[r][m]);
            end
    endtask

    task automatic drive_hs(input logic [NBS-1:0] aw, input logic [NBS-1:0] b,
                            input logic [NBS-1:0] ar, input logic [NBS-1:0] rl);
        aw_hs = aw; b_hs = b; ar_hs = ar; rlast_hs = rl;
        tick();
        aw_hs = '0; b_hs = '0; ar_hs = '0; rlast_hs = '0;
        for (int s = 0; s < NBS; s++) begin
            wcnt[s] = step(wcnt[s], aw[s], b[s]);
            rcnt[s] = step(rcnt[s], ar[s], rl[s]);
        end
    endtask

    task automatic cfg_access(input logic we, input logic [11:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic er, output int n);
        cfg_req = 1; cfg_we = we; cfg_addr = addr; cfg_wdata = wd;
        #1;
        n = 0;
        while (!cfg_gnt && n < 200) begin
            @(posedge clk); #3;
            n++;
        end
        if (n >= 200) chk("gnt_timeout", 32'(cfg_gnt), 32'd1);
        @(posedge clk); #2;
        cfg_req = 0; cfg_we = 0;
        chk("rvalid", 32'(cfg_rvalid), 32'd1);
        rd = cfg_rdata; er = cfg_err;
    endtask

    task automatic reg_wr(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] d, ed;
        logic e, ee;
        int n;
        cfg_access(1, addr, wd, d, e, n);
        exp_read(addr, ed, ee);
        chk("wr_err", 32'(e), 32'(ee));
        model_write(addr, wd);
    endtask

    task automatic reg_rd(input string tag, input logic [11:0] addr);
        logic [31:0] d, ed;
        logic e, ee;
        int n;
        exp_read(addr, ed, ee);
        cfg_access(0, addr, 0, d, e, n);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_err"}, 32'(e), 32'(ee));
    endtask

    task automatic do_commit_idle(input string tag);
        logic [31:0] d;
        logic e;
        int n;
        cfg_access(1, 12'h000, 32'h1, d, e, n);
        chk({tag, "_err"}, 32'(e), 32'd0);
        chk({tag, "_blk_rise"}, 32'(block), 32'hF);
        tick(); tick();
        chk({tag, "_no_done_early"}, 32'(commit_done), 32'd0);
        compare_active({tag, "_pre"});
        tick();
        model_commit();
        chk({tag, "_done"}, 32'(commit_done), 32'd1);
        chk({tag, "_blk_fall"}, 32'(block), 32'd0);
        compare_active({tag, "_post"});
        tick();
        chk({tag, "_done_pulse"}, 32'(commit_done), 32'd0);
    endtask

    task automatic random_regs(input int iters);
        logic [11:0] a;
        int cls;
        for (int i = 0; i < iters; i++) begin
            cls = $urandom_range(9, 0);
            if (cls < 3) a = 12'(128 + 4 * $urandom_range(NBS - 1, 0));
            else if (cls < 9) a = 12'(256 + 16 * $urandom_range(NBR * NBM - 1, 0)
                                      + 4 * $urandom_range(3, 0));
            else a = 12'($urandom_range(4095, 4));
            if ($urandom_range(1, 0) == 1) reg_wr(a, $urandom());
            else reg_rd("rnd_rd", a);
        end
    endtask

    task automatic random_traffic(input int cycles, input int p_inc, input int p_dec);
        logic [NBS-1:0] aw, b, ar, rl;
        int guard;
        for (int c = 0; c < cycles; c++) begin
            for (int s = 0; s < NBS; s++) begin
                aw[s] = ($urandom_range(99, 0) < p_inc);
                ar[s] = ($urandom_range(99, 0) < p_inc);
                b[s]  = ($urandom_range(99, 0) < p_dec);
                rl[s] = ($urandom_range(99, 0) < p_dec);
            end
            drive_hs(aw, b, ar, rl);
        end
        guard = 0;
        while (guard < 100) begin
            aw = '0; ar = '0;
            for (int s = 0; s < NBS; s++) begin
                b[s] = (wcnt[s] > 0);
                rl[s] = (rcnt[s] > 0);
            end
            if (b == '0 && rl == '0) break;
            drive_hs(aw, b, ar, rl);
            guard++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic e;
        int n, done_k, early;

        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_block", 32'(block), 32'd0);
        chk("rst_done", 32'(commit_done), 32'd0);
        chk("rst_rvalid", 32'(cfg_rvalid), 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
        compare_active("rst");
        rst_n = 1;
        tick();
        reg_rd("rst_ctrl", 12'h000);

        random_regs(40);
        reg_rd("dirty_ctrl", 12'h000);

        reg_wr(12'h110, 32'h1000_0000);
        reg_wr(12'h114, 32'h1FFF_FFFF);
        reg_wr(12'h118, 32'h1);
        do_commit_idle("cm1");
        reg_rd("clean_ctrl", 12'h000);

        reg_rd("unmap_7c", 12'h07C);
        reg_wr(12'hFFC, 32'hDEAD_BEEF);
        reg_rd("unmap_90", 12'h090);
        reg_rd("resv_11c", 12'h11C);
        reg_rd("rule_back", 12'h114);

        drive_hs('0, 4'b0001, '0, '0);
        reg_rd("ovf_ctrl", 12'h000);
        reg_wr(12'h088, 32'h0000_00A5);
        do_commit_idle("cm_ovf");
        reg_wr(12'h000, 32'h8);
        reg_rd("ovf_clr", 12'h000);

        reg_wr(12'h088, 32'h0000_003C);
        repeat (3) drive_hs(4'b0100, '0, '0, '0);
        cfg_access(1, 12'h000, 32'h1, d, e, n);
        done_k = -1; early = 0;
        for (int k = 0; k < 40; k++) begin
            if (commit_done) begin
                done_k = k;
                chk("drain_blk_fall", 32'(block), 32'd0);
                break;
            end
            if (block != 4'hF) early = 1;
            if (conn_map[2] != a_conn[2]) early = 1;
            drive_hs('0, (k == 5 || k == 9 || k == 20) ? 4'b0100 : 4'b0000, '0, '0);
        end
        chk("drain_done_cycle", 32'(done_k), 32'd23);
        chk("drain_block_held", 32'(early), 32'd0);
        model_commit();
        compare_active("drain");

        drive_hs('0, '0, 4'b0010, '0);
        reg_wr(12'h080, 32'($urandom_range(255, 0)));
        cfg_access(1, 12'h000, 32'h1, d, e, n);
        m_busy = 1;
        reg_rd("busy_conn", 12'h080);
        reg_rd("busy_ctrl", 12'h000);
        chk("tmo_blk", 32'(block), 32'hF);
        cfg_access(1, 12'h080, 32'h0000_0011, d, e, n);
        chk("tmo_stall", 32'(n), 32'd63);
        m_busy = 0; m_abort = 1;
        model_write(12'h080, 32'h0000_0011);
        chk("tmo_blk_rel", 32'(block), 32'd0);
        compare_active("tmo");
        reg_rd("tmo_ctrl", 12'h000);
        reg_wr(12'h000, 32'h4);
        reg_rd("abort_clr", 12'h000);
        drive_hs('0, '0, '0, 4'b0010);

        random_traffic(300, 50, 30);
        reg_rd("trf1_ctrl", 12'h000);
        reg_wr(12'h000, 32'h8);
        random_regs(10);
        do_commit_idle("cm_trf1");
        random_traffic(300, 20, 40);
        reg_rd("trf2_ctrl", 12'h000);
        random_regs(10);
        do_commit_idle("cm_trf2");

        reg_wr(12'h1FC - 12'h4, 32'h1);
        drive_hs(4'b1000, '0, '0, '0);
        cfg_access(1, 12'h000, 32'h1, d, e, n);
        tick(); tick(); tick();
        #1 rst_n = 0;
        #1;
        model_reset();
        chk("arst_block", 32'(block), 32'd0);
        compare_active("arst");
        #3 rst_n = 1;
        tick();
        reg_rd("arst_ctrl", 12'h000);
        reg_rd("arst_conn", 12'h084);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
